// File: rtl/stepdown_seq_pkg.sv
// Shared types and helpers for the step-down gate-drive sequencer.
// The state encoding is fixed because state_o exposes it for observation.
package stepdown_seq_pkg;

   // Default width of every timing counter and timing input.
   localparam int CNT_W_DEF = 6;

   // Working width of dt_eff; wide enough for any practical CNT_W.
   localparam int DT_FN_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DT_LH = 3'd1,
      HS_ON = 3'd2,
      DT_HL = 3'd3,
      LS_ON = 3'd4
   } seq_state_e;

   // Effective dead time: a programmed 0 still yields one blanking cycle.
   function automatic logic [DT_FN_W-1:0] dt_eff(input logic [DT_FN_W-1:0] dt);
      return (dt == '0) ? DT_FN_W'(1) : dt;
   endfunction

endpackage

// File: rtl/stepdown_dt_timer.sv
// Loadable down-counter shared by both dead-time states.
// Loading N (N >= 1) keeps expired low for N-1 cycles and high on the Nth,
// so a dead-time state loaded on entry lasts exactly N cycles.
module stepdown_dt_timer
   import stepdown_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   // Load on dead-time entry, otherwise count down and rest at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign value   = cnt;
   // A value of 1 marks the last dead-time cycle; 0 is treated the same so
   // an unloaded timer never holds a dead-time state open.
   assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/stepdown_gate_sequencer.sv
// Break-before-make gate-drive sequencer for the step-down power stage.
// Converts the raw PWM request into registered high-side / low-side enables
// with dead time, minimum on-time, OCP blanking, a maximum on-time limit,
// zero-cross (DCM) low-side release and an OCP rearm interlock.
module stepdown_gate_sequencer
   import stepdown_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int BLANK  = 4,
   parameter int MAX_ON = 60
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             SUB,
   input  logic             en,
   input  logic             pwm_i,
   input  logic             ocp_i,
   input  logic             zc_i,
   input  logic [CNT_W-1:0] dt_hl,
   input  logic [CNT_W-1:0] dt_lh,
   input  logic [CNT_W-1:0] min_on,
   output logic             hs_on,
   output logic             ls_on,
   output logic             ocp_flag,
   output logic [2:0]       state_o
);

   localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
   localparam logic [CNT_W-1:0] MAX_ON_C = CNT_W'(MAX_ON);

   seq_state_e       state;
   seq_state_e       next_state;
   logic [CNT_W-1:0] hs_cnt;
   logic             ocp_lock;

   logic             hs_ocp;
   logic             hs_max;
   logic             hs_pwm_off;
   logic             hs_trip;
   logic             hs_enter;
   logic             pwm_go;

   logic             dt_load;
   logic [CNT_W-1:0] dt_load_val;
   logic [CNT_W-1:0] dt_value;
   logic             dt_expired;

   // Supply pins and the raw timer value carry no logic function here.
   logic             unused_ok;
   assign unused_ok = ^{CELV, CELG, SUB, dt_value};

   // One timer serves both dead-time states; they never overlap.
   stepdown_dt_timer #(
      .CNT_W (CNT_W)
   ) u_dt_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dt_load),
      .load_val (dt_load_val),
      .value    (dt_value),
      .expired  (dt_expired)
   );

   // HS exit causes, evaluated against the cycle count of the current pulse.
   always_comb begin
      hs_ocp     = ocp_i && (hs_cnt > BLANK_C);
      hs_max     = (MAX_ON != 0) && (hs_cnt == MAX_ON_C);
      hs_pwm_off = !pwm_i && (hs_cnt >= min_on);
      // A new HS pulse may only be requested once the OCP interlock is clear.
      pwm_go     = pwm_i && !ocp_lock;
   end

   // Next-state decision; shared by the state register and the timer load.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (en && pwm_go) next_state = DT_LH;
         end
         DT_LH: begin
            if (dt_expired) next_state = HS_ON;
         end
         HS_ON: begin
            // en=0 > OCP > MAX_ON > pwm; all of them leave through DT_HL.
            if (!en || hs_ocp || hs_max || hs_pwm_off) next_state = DT_HL;
         end
         DT_HL: begin
            if (dt_expired) next_state = en ? LS_ON : IDLE;
         end
         LS_ON: begin
            // Zero-cross release wins over a simultaneous PWM request.
            if (!en || zc_i)  next_state = IDLE;
            else if (pwm_go)  next_state = DT_LH;
         end
         default: next_state = IDLE;
      endcase
   end

   // Timer load on entry to a dead-time state, dead time sampled only here.
   always_comb begin
      dt_load     = (next_state != state) &&
                    ((next_state == DT_LH) || (next_state == DT_HL));
      dt_load_val = (next_state == DT_HL) ? CNT_W'(dt_eff(DT_FN_W'(dt_hl)))
                                          : CNT_W'(dt_eff(DT_FN_W'(dt_lh)));
      hs_enter    = (state != HS_ON) && (next_state == HS_ON);
      // OCP or MAX_ON ending the pulse; en=0 has priority and is not a trip.
      hs_trip     = (state == HS_ON) && en && (hs_ocp || hs_max);
   end

   // State register with gate enables, pulse counter and OCP bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hs_on    <= 1'b0;
         ls_on    <= 1'b0;
         ocp_flag <= 1'b0;
         hs_cnt   <= '0;
         ocp_lock <= 1'b0;
      end else begin
         state <= next_state;
         // Both enables decode the same next state, so they cannot overlap.
         hs_on <= (next_state == HS_ON);
         ls_on <= (next_state == LS_ON);

         if (hs_enter) begin
            hs_cnt <= CNT_W'(1);
         end else if (next_state == HS_ON) begin
            if (hs_cnt != '1) hs_cnt <= hs_cnt + CNT_W'(1);
         end else begin
            hs_cnt <= '0;
         end

         if (hs_enter) begin
            ocp_flag <= 1'b0;
         end else if (hs_trip) begin
            ocp_flag <= 1'b1;
         end

         // The interlock clears only after pwm_i has been seen low.
         if (hs_trip) begin
            ocp_lock <= 1'b1;
         end else if (!pwm_i) begin
            ocp_lock <= 1'b0;
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_stepdown_gate_sequencer.sv
// Self-checking bench for stepdown_gate_sequencer.
module tb_stepdown_gate_sequencer;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DT_LH = 3'd1;
   localparam logic [2:0] S_HS_ON = 3'd2;
   localparam logic [2:0] S_DT_HL = 3'd3;
   localparam logic [2:0] S_LS_ON = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       celv = 1'b1;
   logic       celg = 1'b0;
   logic       sub = 1'b0;
   logic       en = 1'b0;
   logic       pwm_i = 1'b0;
   logic       ocp_i = 1'b0;
   logic       zc_i = 1'b0;
   logic [5:0] dt_hl = 6'd1;
   logic [5:0] dt_lh = 6'd1;
   logic [5:0] min_on = 6'd1;
   logic       hs_on;
   logic       ls_on;
   logic       ocp_flag;
   logic [2:0] state_o;

   int errors = 0;
   int checks = 0;
   int overlap_cnt = 0;
   logic [7:0] exp_q[$];

   stepdown_gate_sequencer #(
      .CNT_W  (6),
      .BLANK  (4),
      .MAX_ON (60)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .CELV     (celv),
      .CELG     (celg),
      .SUB      (sub),
      .en       (en),
      .pwm_i    (pwm_i),
      .ocp_i    (ocp_i),
      .zc_i     (zc_i),
      .dt_hl    (dt_hl),
      .dt_lh    (dt_lh),
      .min_on   (min_on),
      .hs_on    (hs_on),
      .ls_on    (ls_on),
      .ocp_flag (ocp_flag),
      .state_o  (state_o)
   );

   // clock / overlap monitor
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (hs_on === 1'b1 && ls_on === 1'b1) overlap_cnt++;
   end

   function automatic int eff(input int x);
      return (x == 0) ? 1 : x;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Advance to just after the next active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Return to IDLE through the zero-cross release.
   task automatic settle(input string name);
      int n;
      pwm_i = 1'b0;
      ocp_i = 1'b0;
      en    = 1'b1;
      zc_i  = 1'b1;
      n = 0;
      while (state_o !== S_IDLE && n < 100) begin
         step();
         n++;
      end
      zc_i = 1'b0;
      checks++;
      if (state_o !== S_IDLE) begin
         errors++;
         $display("FAIL %s_settle: state=%0d expected=%0d", name, state_o, S_IDLE);
      end
   endtask

   // One PWM pulse held for h HS cycles: rise latency, HS width, LS delay.
   task automatic pulse_and_check(input string name, input int h, input int dl,
                                  input int dh, input int mo);
      int n;
      int w;
      int d;
      logic [7:0] e;
      dt_lh  = 6'(dl);
      dt_hl  = 6'(dh);
      min_on = 6'(mo);
      en     = 1'b1;
      zc_i   = 1'b0;
      ocp_i  = 1'b0;
      exp_q.push_back(8'(1 + eff(dl)));
      exp_q.push_back(8'(max3(h, mo, 1)));
      exp_q.push_back(8'(eff(dh)));
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (n !== int'(e)) begin
         errors++;
         $display("FAIL %s_rise: got %0d cycles expected %0d", name, n, e);
      end
      w = 0;
      while (hs_on === 1'b1 && w < 200) begin
         w++;
         if (w == h) pwm_i = 1'b0;
         step();
      end
      pwm_i = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (w !== int'(e)) begin
         errors++;
         $display("FAIL %s_width: got %0d cycles expected %0d", name, w, e);
      end
      d = 0;
      while (ls_on !== 1'b1 && d < 200) begin
         step();
         d++;
      end
      e = exp_q.pop_front();
      checks++;
      if (d !== int'(e)) begin
         errors++;
         $display("FAIL %s_ls_delay: got %0d cycles expected %0d", name, d, e);
      end
      zc_i = 1'b1;
      step();
      zc_i = 1'b0;
      checks++;
      if (state_o !== S_IDLE || ls_on !== 1'b0) begin
         errors++;
         $display("FAIL %s_zc_release: state=%0d ls_on=%0b expected state=0 ls_on=0",
                  name, state_o, ls_on);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      step();
      step();
      checks++;
      if (state_o !== S_IDLE || hs_on !== 1'b0 || ls_on !== 1'b0 || ocp_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset: state=%0d hs=%0b ls=%0b flag=%0b expected all 0",
                  state_o, hs_on, ls_on, ocp_flag);
      end
      rst_n = 1'b1;
      en = 1'b1;
      step();
      checks++;
      if (state_o !== S_IDLE) begin
         errors++;
         $display("FAIL reset_idle: state=%0d expected=0", state_o);
      end
   endtask

   // dt_lh=3, dt_hl=2, min_on=5, PWM held through 10 HS cycles.
   task automatic test_basic();
      pulse_and_check("basic", 10, 3, 2, 5);
   endtask

   task automatic test_min_on();
      pulse_and_check("min_on", 2, 3, 2, 5);
   endtask

   task automatic test_dt_zero();
      pulse_and_check("dt_zero", 3, 0, 0, 1);
   endtask

   task automatic test_random_pulses();
      for (int i = 0; i < 8; i++) begin
         pulse_and_check("random", int'($urandom_range(1, 12)), int'($urandom_range(0, 5)),
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 10)));
      end
   endtask

   task automatic test_ocp();
      int n;
      int w;
      logic [7:0] e;
      dt_lh = 6'd1;
      dt_hl = 6'd1;
      min_on = 6'd1;
      en = 1'b1;
      exp_q.push_back(8'd6);
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      w = 0;
      while (hs_on === 1'b1 && w < 100) begin
         w++;
         ocp_i = (w == 2 || w == 6);
         step();
      end
      ocp_i = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (w !== int'(e)) begin
         errors++;
         $display("FAIL ocp_width: got %0d cycles expected %0d", w, e);
      end
      checks++;
      if (ocp_flag !== 1'b1) begin
         errors++;
         $display("FAIL ocp_flag: got %0b expected 1", ocp_flag);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (state_o !== S_LS_ON || hs_on !== 1'b0) begin
            errors++;
            $display("FAIL ocp_rearm_hold: state=%0d hs=%0b expected state=4 hs=0",
                     state_o, hs_on);
         end
      end
      pwm_i = 1'b0;
      step();
      pwm_i = 1'b1;
      step();
      checks++;
      if (state_o !== S_DT_LH || ocp_flag !== 1'b1) begin
         errors++;
         $display("FAIL ocp_rearm_go: state=%0d flag=%0b expected state=1 flag=1",
                  state_o, ocp_flag);
      end
      step();
      checks++;
      if (hs_on !== 1'b1 || ocp_flag !== 1'b0) begin
         errors++;
         $display("FAIL ocp_flag_clear: hs=%0b flag=%0b expected hs=1 flag=0", hs_on, ocp_flag);
      end
      settle("ocp");
   endtask

   task automatic test_max_on();
      int n;
      int w;
      logic [7:0] e;
      dt_lh = 6'd1;
      dt_hl = 6'd1;
      min_on = 6'd1;
      en = 1'b1;
      exp_q.push_back(8'd60);
      exp_q.push_back(8'd2);
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      w = 0;
      while (hs_on === 1'b1 && w < 100) begin
         w++;
         step();
      end
      e = exp_q.pop_front();
      checks++;
      if (w !== int'(e) || ocp_flag !== 1'b1) begin
         errors++;
         $display("FAIL max_on: width=%0d flag=%0b expected width=%0d flag=1", w, ocp_flag, e);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (state_o !== S_LS_ON) begin
            errors++;
            $display("FAIL max_on_hold: state=%0d expected=4", state_o);
         end
      end
      pwm_i = 1'b0;
      step();
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (n !== int'(e)) begin
         errors++;
         $display("FAIL max_on_repulse: got %0d cycles expected %0d", n, e);
      end
      settle("max_on");
   endtask

   task automatic test_dcm();
      int n;
      dt_lh = 6'd1;
      dt_hl = 6'd1;
      min_on = 6'd1;
      en = 1'b1;
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      pwm_i = 1'b0;
      n = 0;
      while (ls_on !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      zc_i = 1'b1;
      pwm_i = 1'b1;
      step();
      zc_i = 1'b0;
      checks++;
      if (state_o !== S_IDLE || ls_on !== 1'b0) begin
         errors++;
         $display("FAIL dcm_release: state=%0d ls=%0b expected state=0 ls=0", state_o, ls_on);
      end
      step();
      checks++;
      if (state_o !== S_DT_LH) begin
         errors++;
         $display("FAIL dcm_restart: state=%0d expected=1", state_o);
      end
      settle("dcm");
   endtask

   task automatic test_en_drop();
      int n;
      dt_lh = 6'd1;
      dt_hl = 6'd3;
      min_on = 6'd1;
      en = 1'b1;
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      step();
      en = 1'b0;
      step();
      checks++;
      if (state_o !== S_DT_HL || hs_on !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_dt: state=%0d hs=%0b expected state=3 hs=0", state_o, hs_on);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (ls_on !== 1'b0 || state_o !== ((i == 3) ? S_IDLE : S_DT_HL)) begin
            errors++;
            $display("FAIL en_drop_seq: cycle=%0d state=%0d ls=%0b expected state=%0d ls=0",
                     i, state_o, ls_on, (i == 3) ? S_IDLE : S_DT_HL);
         end
      end
      pwm_i = 1'b0;
      en = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      dt_lh = 6'd1;
      en = 1'b1;
      pwm_i = 1'b1;
      n = 0;
      while (hs_on !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (hs_on !== 1'b0 || ls_on !== 1'b0 || state_o !== S_IDLE) begin
         errors++;
         $display("FAIL reset_async: hs=%0b ls=%0b state=%0d expected 0 0 0",
                  hs_on, ls_on, state_o);
      end
      pwm_i = 1'b0;
      #1 rst_n = 1'b1;
      step();
      checks++;
      if (state_o !== S_IDLE || ocp_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: state=%0d flag=%0b expected 0 0", state_o, ocp_flag);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_on();
      test_dt_zero();
      test_random_pulses();
      test_ocp();
      test_max_on();
      test_dcm();
      test_en_drop();
      test_reset_mid();
      checks++;
      if (overlap_cnt !== 0) begin
         errors++;
         $display("FAIL no_overlap: overlapping cycles=%0d expected 0", overlap_cnt);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
